// File: rtl/fetch_unit.sv
// Instruction-fetch stage: one-entry address-tagged buffer in front of a req/gnt/rvalid
// instruction bus, with misalignment, bus-error and response-timeout reporting.
module fetch_unit #(
  parameter logic [31:0] NOOP           = 32'h0000_0013,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        i_CLK,
  input  logic        i_RST,
  input  logic [31:0] i_PC,
  output logic [31:0] o_INSTRUCTION,
  output logic        o_INSTRUCTION_VALID,
  output logic        o_FETCH_ERR,
  output logic        o_MISALIGNED,
  output logic        o_IMEM_REQ,
  output logic [31:0] o_IMEM_ADDR,
  input  logic        i_IMEM_GNT,
  input  logic        i_IMEM_RVALID,
  input  logic [31:0] i_IMEM_RDATA,
  input  logic        i_IMEM_ERR
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_addr_q, buf_addr_d;
  logic [31:0] buf_data_q, buf_data_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic        fetch_err_q, fetch_err_d;
  logic        err_blk_q, err_blk_d;
  logic [31:0] err_addr_q, err_addr_d;

  logic hit;
  logic blocked;

  assign o_MISALIGNED        = (i_PC[1:0] != 2'b00);
  assign hit                 = buf_valid_q && (buf_addr_q == i_PC);
  assign blocked             = err_blk_q && (err_addr_q == i_PC);
  assign o_INSTRUCTION_VALID = hit && !o_MISALIGNED && (state_q == S_IDLE);
  assign o_INSTRUCTION       = o_INSTRUCTION_VALID ? buf_data_q : NOOP;
  assign o_FETCH_ERR         = fetch_err_q;
  assign o_IMEM_REQ          = req_q;
  assign o_IMEM_ADDR         = addr_q;

  always_comb begin
    // NOTE: every _d starts as its _q so no path through the case leaves a signal unassigned (no latch).
    state_d     = state_q;
    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    addr_d      = addr_q;
    fetch_err_d = fetch_err_q;
    err_blk_d   = err_blk_q;
    err_addr_d  = err_addr_q;

    unique case (state_q)
      S_IDLE: begin
        // A failed address is not retried until decode moves away from it.
        if (err_blk_q && !blocked) err_blk_d = 1'b0;
        if (!hit && !o_MISALIGNED && !blocked) begin
          state_d = S_REQ;
          req_d   = 1'b1;
          addr_d  = {i_PC[31:2], 2'b00};
        end
      end
      S_REQ: begin
        if (i_IMEM_GNT) begin
          state_d     = S_WAIT;
          req_d       = 1'b0;
          fetch_err_d = 1'b0;
          cnt_d       = 8'd0;
        end
      end
      S_WAIT: begin
        cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        if (i_IMEM_RVALID) begin
          state_d = S_IDLE;
          if (i_IMEM_ERR) begin
            buf_valid_d = 1'b0;
            fetch_err_d = 1'b1;
            err_blk_d   = 1'b1;
            err_addr_d  = addr_q;
          end else begin
            buf_valid_d = 1'b1;
            buf_addr_d  = addr_q;
            buf_data_d  = i_IMEM_RDATA;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d     = S_IDLE;
          buf_valid_d = 1'b0;
          fetch_err_d = 1'b1;
          err_blk_d   = 1'b1;
          err_addr_d  = addr_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q     <= S_IDLE;
      buf_valid_q <= 1'b0;
      buf_addr_q  <= 32'd0;
      buf_data_q  <= NOOP;
      cnt_q       <= 8'd0;
      req_q       <= 1'b0;
      addr_q      <= 32'd0;
      fetch_err_q <= 1'b0;
      err_blk_q   <= 1'b0;
      err_addr_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      fetch_err_q <= fetch_err_d;
      err_blk_q   <= err_blk_d;
      err_addr_q  <= err_addr_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: hand-computed expectations for fills, hits, stalls,
// bus errors, timeout, misalignment and reset during an outstanding request.
module tb_fetch_unit;

  localparam logic [31:0] NOOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        fetch_err;
  logic        misaligned;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        imem_err;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_unit #(.NOOP(NOOP), .TIMEOUT_CYCLES(4)) dut (
    .i_CLK              (clk),
    .i_RST              (rst),
    .i_PC               (pc),
    .o_INSTRUCTION      (instr),
    .o_INSTRUCTION_VALID(instr_valid),
    .o_FETCH_ERR        (fetch_err),
    .o_MISALIGNED       (misaligned),
    .o_IMEM_REQ         (imem_req),
    .o_IMEM_ADDR        (imem_addr),
    .i_IMEM_GNT         (imem_gnt),
    .i_IMEM_RVALID      (imem_rvalid),
    .i_IMEM_RDATA       (imem_rdata),
    .i_IMEM_ERR         (imem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are changed 1ns after the edge and outputs sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; pc = 32'h0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    imem_rdata = 32'h0; imem_err = 1'b0;
    tick(); tick(); settle();
    check("rst_req",   {31'd0, imem_req},    32'd0);
    check("rst_addr",  imem_addr,            32'd0);
    check("rst_err",   {31'd0, fetch_err},   32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", instr,                NOOP);

    // Miss at 0x0: REQ next cycle, GNT immediate, RVALID one later, VALID on the third cycle.
    rst = 1'b0; pc = 32'h0; settle();
    check("c0_valid", {31'd0, instr_valid}, 32'd0);
    tick(); settle();
    check("c1_req",  {31'd0, imem_req}, 32'd1);
    check("c1_addr", imem_addr,         32'h0);
    imem_gnt = 1'b1;
    tick(); imem_gnt = 1'b0; settle();
    check("c2_req", {31'd0, imem_req}, 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
    tick(); imem_rvalid = 1'b0; imem_rdata = 32'h0; settle();
    check("c3_valid", {31'd0, instr_valid}, 32'd1);
    check("c3_instr", instr,                32'h0050_0093);

    // Hold the PC: stays a hit with no bus traffic.
    for (int i = 0; i < 3; i++) begin
      tick(); settle();
      check("hold_req",   {31'd0, imem_req},    32'd0);
      check("hold_valid", {31'd0, instr_valid}, 32'd1);
    end

    // Move to 0x4: valid drops at once, request the cycle after.
    pc = 32'h4; settle();
    check("pc4_valid", {31'd0, instr_valid}, 32'd0);
    check("pc4_instr", instr,                NOOP);
    tick(); settle();
    check("pc4_req",  {31'd0, imem_req}, 32'd1);
    check("pc4_addr", imem_addr,         32'h4);
    imem_gnt = 1'b1;
    tick(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0010_0113;
    tick(); imem_rvalid = 1'b0; settle();
    check("pc4_instr_ok", instr, 32'h0010_0113);

    // Grant withheld for 5 cycles at 0x8.
    pc = 32'h8;
    tick(); settle();
    for (int i = 0; i < 5; i++) begin
      check("stall_req",  {31'd0, imem_req}, 32'd1);
      check("stall_addr", imem_addr,         32'h8);
      tick(); settle();
    end
    imem_gnt = 1'b1;
    tick(); imem_gnt = 1'b0; settle();
    check("stall_gnt_req", {31'd0, imem_req}, 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick(); imem_rvalid = 1'b0; settle();
    check("stall_valid", {31'd0, instr_valid}, 32'd1);
    check("stall_instr", instr,                32'hDEAD_BEEF);

    // Bus error at 0x10: sticky error, no retry while PC stays.
    pc = 32'h10;
    tick(); imem_gnt = 1'b1;
    tick(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_err = 1'b1; imem_rdata = 32'h1234_5678;
    tick(); imem_rvalid = 1'b0; imem_err = 1'b0; settle();
    check("berr_err",   {31'd0, fetch_err},   32'd1);
    check("berr_valid", {31'd0, instr_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick(); settle();
      check("berr_noreq", {31'd0, imem_req}, 32'd0);
    end
    pc = 32'h14;
    tick(); settle();
    check("retry_req",  {31'd0, imem_req},  32'd1);
    check("retry_addr", imem_addr,          32'h14);
    check("retry_err",  {31'd0, fetch_err}, 32'd1);
    imem_gnt = 1'b1;
    tick(); imem_gnt = 1'b0; settle();
    check("retry_gnt_err", {31'd0, fetch_err}, 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'h0020_0193;
    tick(); imem_rvalid = 1'b0; settle();
    check("retry_instr", instr, 32'h0020_0193);

    // Timeout with TIMEOUT_CYCLES=4: error after the 4th wait cycle.
    pc = 32'h20;
    tick(); imem_gnt = 1'b1;
    tick(); imem_gnt = 1'b0; settle();
    for (int i = 0; i < 4; i++) begin
      check("to_wait_err", {31'd0, fetch_err}, 32'd0);
      tick(); settle();
    end
    check("to_err",   {31'd0, fetch_err},   32'd1);
    check("to_valid", {31'd0, instr_valid}, 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'hCAFE_F00D;
    tick(); imem_rvalid = 1'b0; settle();
    check("late_valid", {31'd0, instr_valid}, 32'd0);
    check("late_instr", instr,                NOOP);
    check("late_req",   {31'd0, imem_req},    32'd0);

    // Misaligned PC: flagged, never requested.
    pc = 32'h6; settle();
    check("mis_flag",  {31'd0, misaligned},  32'd1);
    check("mis_instr", instr,                NOOP);
    tick(); tick(); settle();
    check("mis_req", {31'd0, imem_req}, 32'd0);

    // Reset while waiting for a response.
    pc = 32'h24;
    tick(); imem_gnt = 1'b1;
    tick(); imem_gnt = 1'b0; rst = 1'b1;
    tick(); rst = 1'b0; settle();
    check("rstw_req",   {31'd0, imem_req},    32'd0);
    check("rstw_valid", {31'd0, instr_valid}, 32'd0);
    check("rstw_err",   {31'd0, fetch_err},   32'd0);
    pc = 32'h6; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    tick(); imem_rvalid = 1'b0; pc = 32'h0; settle();
    check("rstw_late_valid", {31'd0, instr_valid}, 32'd0);
    check("rstw_late_instr", instr,                NOOP);
    tick(); settle();
    check("rstw_new_req",  {31'd0, imem_req}, 32'd1);
    check("rstw_new_addr", imem_addr,         32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
